// File: rtl/pinwheel_regfile_ctrl_if.sv
// rtl/pinwheel_regfile_ctrl_if.sv - operand-read request/response and writeback bus for the pinwheel regfile controller
interface pinwheel_regfile_ctrl_if;
  // operand-read request
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_hart;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;

  // operand-read response
  logic        rsp_valid;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;

  // writeback, no backpressure
  logic        wb_valid;
  logic [1:0]  wb_hart;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // pipeline side issuing reads and writebacks
  modport master (
    output req_valid, req_hart, req_rs1, req_rs2,
    input  req_ready,
    input  rsp_valid, rsp_rs1_data, rsp_rs2_data,
    output wb_valid, wb_hart, wb_rd, wb_data
  );

  // regfile controller side
  modport slave (
    input  req_valid, req_hart, req_rs1, req_rs2,
    output req_ready,
    output rsp_valid, rsp_rs1_data, rsp_rs2_data,
    input  wb_valid, wb_hart, wb_rd, wb_data
  );
endinterface

// File: rtl/pinwheel_regfile_ctrl.sv
// rtl/pinwheel_regfile_ctrl.sv - 4-hart x 32-reg regfile controller: power-up clear, operand reads with writeback bypass
module pinwheel_regfile_ctrl (
  input  logic                        clk,
  input  logic                        rst_n,
  pinwheel_regfile_ctrl_if.slave      bus,
  output logic [7:0]                  rf_raddr0,
  input  logic [31:0]                 rf_rdata0,
  output logic [7:0]                  rf_raddr1,
  input  logic [31:0]                 rf_rdata1,
  output logic [7:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic                        rf_wren,
  output logic                        init_done
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  clr_cnt_q;
  logic [6:0]  clr_cnt_d;
  logic        run;

  // writeback qualification: x0 writes never reach the RAM nor the bypass path
  logic        wb_live;
  logic        accept;
  logic        byp1;
  logic        byp2;

  // response-cycle state captured at the accept edge
  logic        rsp_valid_q;
  logic        rs1_zero_q;
  logic        rs2_zero_q;
  logic        byp1_q;
  logic        byp2_q;
  logic [31:0] byp_data_q;

  assign wb_live = bus.wb_valid & (bus.wb_rd != 5'd0);
  assign accept  = bus.req_valid & run;

  // A writeback landing in the accept cycle is not visible to the RAM read
  // (old data on read-during-write), so the operand is forwarded instead.
  assign byp1 = accept & wb_live & (bus.wb_hart == bus.req_hart) & (bus.wb_rd == bus.req_rs1);
  assign byp2 = accept & wb_live & (bus.wb_hart == bus.req_hart) & (bus.wb_rd == bus.req_rs2);

  // Read addresses follow the request bus every cycle; the RAM latches them at the edge.
  assign rf_raddr0 = {1'b0, bus.req_hart, bus.req_rs1};
  assign rf_raddr1 = {1'b0, bus.req_hart, bus.req_rs2};

  assign bus.req_ready = run;
  assign init_done     = run;

  // state and clear-address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // next state, clear walk and write-port mux
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    run       = 1'b0;
    rf_wren   = 1'b0;
    rf_waddr  = 8'd0;
    rf_wdata  = 32'd0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        rf_wren   = 1'b1;
        rf_waddr  = {1'b0, clr_cnt_q};
        rf_wdata  = 32'd0;
        clr_cnt_d = clr_cnt_q + 7'd1;
        if (clr_cnt_q == 7'd127) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run      = 1'b1;
        rf_wren  = wb_live;
        rf_waddr = {1'b0, bus.wb_hart, bus.wb_rd};
        rf_wdata = bus.wb_data;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // capture per-operand zero/bypass decisions for the single response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rs1_zero_q  <= 1'b0;
      rs2_zero_q  <= 1'b0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp_data_q  <= 32'd0;
    end else begin
      rsp_valid_q <= accept;
      rs1_zero_q  <= (bus.req_rs1 == 5'd0);
      rs2_zero_q  <= (bus.req_rs2 == 5'd0);
      byp1_q      <= byp1;
      byp2_q      <= byp2;
      if (byp1 | byp2) begin
        byp_data_q <= bus.wb_data;
      end
    end
  end

  // response data mux; data is forced to zero outside the response cycle
  always_comb begin
    bus.rsp_valid    = rsp_valid_q;
    bus.rsp_rs1_data = 32'd0;
    bus.rsp_rs2_data = 32'd0;
    if (rsp_valid_q) begin
      if (rs1_zero_q) begin
        bus.rsp_rs1_data = 32'd0;
      end else if (byp1_q) begin
        bus.rsp_rs1_data = byp_data_q;
      end else begin
        bus.rsp_rs1_data = rf_rdata0;
      end
      if (rs2_zero_q) begin
        bus.rsp_rs2_data = 32'd0;
      end else if (byp2_q) begin
        bus.rsp_rs2_data = byp_data_q;
      end else begin
        bus.rsp_rs2_data = rf_rdata1;
      end
    end
  end

endmodule

// File: tb/tb_pinwheel_regfile_ctrl.sv
// tb/tb_pinwheel_regfile_ctrl.sv - directed self-checking bench for pinwheel_regfile_ctrl
module tb_pinwheel_regfile_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rf_raddr0;
  logic [31:0] rf_rdata0;
  logic [7:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [7:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren;
  logic        init_done;

  int n_cmp;
  int n_fail;

  logic [31:0] mem [0:255];

  pinwheel_regfile_ctrl_if bus();

  pinwheel_regfile_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .rf_raddr0 (rf_raddr0),
    .rf_rdata0 (rf_rdata0),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata1 (rf_rdata1),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wren   (rf_wren),
    .init_done (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dual-read single-write RAM, 1-cycle read, old data on read-during-write
  always @(posedge clk) begin
    if (rf_wren) mem[rf_waddr] <= rf_wdata;
    rf_rdata0 <= mem[rf_raddr0];
    rf_rdata1 <= mem[rf_raddr1];
  end

  task automatic set_idle();
    bus.req_valid = 1'b0;
    bus.req_hart  = 2'd0;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.wb_valid  = 1'b0;
    bus.wb_hart   = 2'd0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bus.req_ready, init_done, rf_wren, bus.rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready/done/wren/rsp=%b required 0000",
               {bus.req_ready, init_done, rf_wren, bus.rsp_valid});
    end
    n_cmp++;
    if ({bus.rsp_rs1_data, bus.rsp_rs2_data} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rsp_data: got %h_%h required 0", bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
  endtask

  // expects rst_n low on entry; releases it and walks the full clear
  task automatic test_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({rf_wren, init_done, bus.req_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL init_cycle: got wren/done/ready=%b required 000", {rf_wren, init_done, bus.req_ready});
    end
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rf_wren !== 1'b1 || rf_waddr !== 8'(i) || rf_wdata !== 32'd0 ||
          init_done !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_step%0d: got wren=%b waddr=%h wdata=%h done=%b ready=%b required 1 %h 0 0 0",
                 i, rf_wren, rf_waddr, rf_wdata, init_done, bus.req_ready, 8'(i));
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({init_done, bus.req_ready, rf_wren} !== 3'b110) begin
      n_fail++;
      $display("FAIL clear_done: got done/ready/wren=%b required 110", {init_done, bus.req_ready, rf_wren});
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd2; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (rf_wren !== 1'b1 || rf_waddr !== 8'h45 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wb_port: got wren=%b waddr=%h wdata=%h required 1 45 deadbeef", rf_wren, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    set_idle();
    bus.req_valid = 1'b1; bus.req_hart = 2'd2; bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (rf_raddr0 !== 8'h45 || rf_raddr1 !== 8'h40 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_addr: got raddr0=%h raddr1=%h rsp_valid=%b required 45 40 0", rf_raddr0, rf_raddr1, bus.rsp_valid);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'hDEADBEEF || bus.rsp_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL read_rsp: got v=%b rs1=%h rs2=%h required 1 deadbeef 0", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rs1_data !== 32'd0 || bus.rsp_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL rsp_single: got v=%b rs1=%h rs2=%h required 0 0 0", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd1; bus.wb_rd = 5'd7; bus.wb_data = 32'h12345678;
    bus.req_valid = 1'b1; bus.req_hart = 2'd1; bus.req_rs1 = 5'd7; bus.req_rs2 = 5'd7;
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'h12345678 || bus.rsp_rs2_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass_same: got v=%b rs1=%h rs2=%h required 1 12345678 12345678", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
    // writeback to another hart's x7 must not be forwarded into hart1's read
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd0; bus.wb_rd = 5'd7; bus.wb_data = 32'hCAFEF00D;
    bus.req_valid = 1'b1; bus.req_hart = 2'd1; bus.req_rs1 = 5'd7; bus.req_rs2 = 5'd6;
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_rs1_data !== 32'h12345678 || bus.rsp_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_other_hart: got rs1=%h rs2=%h required 12345678 0", bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
    // write in the response cycle is ordered after the read
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_hart = 2'd2; bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd5;
    @(negedge clk);
    set_idle();
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd2; bus.wb_rd = 5'd5; bus.wb_data = 32'h11111111;
    #1;
    n_cmp++;
    if (bus.rsp_rs1_data !== 32'hDEADBEEF || bus.rsp_rs2_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_after_read: got rs1=%h rs2=%h required deadbeef deadbeef", bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
    @(negedge clk);
    set_idle();
    bus.req_valid = 1'b1; bus.req_hart = 2'd2; bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd0;
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_rs1_data !== 32'h11111111) begin
      n_fail++;
      $display("FAIL write_visible_later: got rs1=%h required 11111111", bus.rsp_rs1_data);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd0; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    bus.req_valid = 1'b1; bus.req_hart = 2'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (rf_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_wren: got %b required 0", rf_wren);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'd0 || bus.rsp_rs2_data !== 32'd0 || mem[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_read: got v=%b rs1=%h rs2=%h ram0=%h required 1 0 0 0", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data, mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd0; bus.wb_rd = 5'd3; bus.wb_data = 32'd1;
    #1;
    n_cmp++;
    if (rf_waddr !== 8'h03 || rf_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL iso_waddr0: got waddr=%h wren=%b required 03 1", rf_waddr, rf_wren);
    end
    @(negedge clk);
    bus.wb_hart = 2'd3; bus.wb_data = 32'd2;
    #1;
    n_cmp++;
    if (rf_waddr !== 8'h63 || rf_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL iso_waddr3: got waddr=%h wren=%b required 63 1", rf_waddr, rf_wren);
    end
    @(negedge clk);
    set_idle();
    bus.req_valid = 1'b1; bus.req_hart = 2'd0; bus.req_rs1 = 5'd3; bus.req_rs2 = 5'd3;
    @(negedge clk);
    bus.req_hart = 2'd3; bus.req_rs1 = 5'd3; bus.req_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'd1 || bus.rsp_rs2_data !== 32'd1) begin
      n_fail++;
      $display("FAIL iso_hart0: got v=%b rs1=%h rs2=%h required 1 1 1", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'd2 || bus.rsp_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL iso_hart3: got v=%b rs1=%h rs2=%h required 1 2 0", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    n_cmp++;
    if (rf_wren !== 1'b1 || rf_waddr !== 8'h0A) begin
      n_fail++;
      $display("FAIL partial_clear: got wren=%b waddr=%h required 1 0a", rf_wren, rf_waddr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_wren !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_clear: got wren=%b done=%b required 0 0", rf_wren, init_done);
    end
    test_clear();
  endtask

  task automatic test_reset_mid_rsp();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_hart = 2'd1; bus.req_rs1 = 5'd7; bus.req_rs2 = 5'd7;
    @(posedge clk);
    #2;
    bus.wb_valid = 1'b1; bus.wb_hart = 2'd1; bus.wb_rd = 5'd9; bus.wb_data = 32'h55AA55AA;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || rf_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_rsp: got v=%b wren=%b required 1 1", bus.rsp_valid, rf_wren);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || rf_wren !== 1'b0 || bus.rsp_rs1_data !== 32'd0 ||
        bus.req_ready !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_rsp: got v=%b wren=%b rs1=%h ready=%b done=%b required 0 0 0 0 0",
               bus.rsp_valid, rf_wren, bus.rsp_rs1_data, bus.req_ready, init_done);
    end
    set_idle();
    test_clear();
    // regfile contents from before the reset must be wiped
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_hart = 2'd1; bus.req_rs1 = 5'd7; bus.req_rs2 = 5'd7;
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'd0 || bus.rsp_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL wiped_after_reset: got v=%b rs1=%h rs2=%h required 1 0 0", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hBAD00000 | 32'(i);
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_clear();
    test_write_read();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_reset_mid_clear();
    test_reset_mid_rsp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pinwheel_regfile_ctrl.md
PINWHEEL_REGFILE_CTRL -- requirements
Module: pinwheel_regfile_ctrl

Interface
REQ-001 SHALL have no parameters; fixed 4 harts x 32 regs x 32 bits.
REQ-002 SHALL have port: clk  in  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1 (operand-read handshake); req_hart in 2, req_rs1 in 5, req_rs2 in 5 (hart and source register indices).
REQ-005 SHALL have ports: rsp_valid out 1, rsp_rs1_data out 32, rsp_rs2_data out 32 (operand results).
REQ-006 SHALL have ports: wb_valid in 1, wb_hart in 2, wb_rd in 5, wb_data in 32 (writeback; no ready).
REQ-007 SHALL have ports: rf_raddr0 out 8, rf_rdata0 in 32, rf_raddr1 out 8, rf_rdata1 in 32, rf_waddr out 8, rf_wdata out 32, rf_wren out 1 (drive a dual-read, single-write RAM regfile, 1-cycle synchronous read, read-during-write returns old data).
REQ-008 SHALL have port: init_done out 1 (regfile clear complete).

Function
REQ-009 SHALL form every RAM address as {1'b0, hart[1:0], reg[4:0]}; bit 7 always 0.
REQ-010 SHALL implement states INIT, CLEAR, RUN; INIT->CLEAR after 1 cycle; CLEAR->RUN after 128 cycles; RUN is terminal until reset.
REQ-011 In CLEAR SHALL assert rf_wren=1, rf_wdata=0, rf_waddr=7-bit counter (0..127, +1 per cycle); counter reaching 127 exits to RUN next cycle.
REQ-012 In INIT and CLEAR SHALL hold req_ready=0, init_done=0, and ignore wb_valid (writes dropped).
REQ-013 In RUN SHALL hold req_ready=1 and init_done=1; a request is accepted on req_valid & req_ready.
REQ-014 SHALL drive rf_raddr0/rf_raddr1 combinationally from req_hart/req_rs1 and req_hart/req_rs2 every cycle.
REQ-015 SHALL assert rsp_valid for exactly 1 cycle, the cycle after acceptance; back-to-back accepts give back-to-back rsp_valid.
REQ-016 rsp_rsN_data SHALL be 0 when rsp_valid=0; when 1, = 0 if rsN was 0, else bypass data if flagged (REQ-017), else rf_rdataN.
REQ-017 SHALL flag bypass per operand when, in the accept cycle, wb_valid=1, wb_rd!=0, wb_hart==req_hart, wb_rd==req_rsN; SHALL register wb_data for that operand.
REQ-018 A write in the response cycle SHALL NOT affect that response (write ordered after read).
REQ-019 In RUN SHALL drive rf_wren = wb_valid & (wb_rd!=0), rf_waddr from wb_hart/wb_rd, rf_wdata = wb_data, combinationally, same cycle.
REQ-020 Writes to x0 SHALL never reach the RAM; x0 SHALL always read 0.
REQ-021 rs1==rs2 SHALL return identical data on both operands, including bypass.

Reset
REQ-022 rst_n low SHALL immediately force: state=INIT, counter=0, rsp_valid=0, bypass flags=0, req_ready=0, init_done=0, rf_wren=0, rsp data=0.
REQ-023 Reset mid-CLEAR SHALL restart clear at address 0; reset in RUN SHALL drop any pending response and rerun full clear.
REQ-024 Reset release SHALL give first rf_wren on the 2nd rising edge's cycle (after INIT) and init_done=1 exactly 129 cycles after first edge.

Verification
REQ-025 Release rst_n -> 1 INIT cycle, 128 cycles rf_wren=1 with rf_waddr 0x00..0x7F, rf_wdata=0, then init_done=1, req_ready=1.
REQ-026 wb hart2 rd5=0xDEADBEEF; later req hart2 rs1=5 rs2=0 -> rf_raddr0=0x45; next cycle rsp_valid=1, rs1=0xDEADBEEF, rs2=0.
REQ-027 Same cycle: wb hart1 rd7=0x12345678 and req hart1 rs1=7 rs2=7 -> both rsp data 0x12345678 (bypass).
REQ-028 wb_valid with wb_rd=0, wb_data=0xFFFFFFFF -> rf_wren stays 0; read x0 returns 0.
REQ-029 wb hart0 x3=1, hart3 x3=2; read hart0 x3 and hart3 x3 -> 1 and 2 (hart isolation, addresses 0x03/0x63).
REQ-030 Accept request, assert rst_n=0 before response edge -> rsp_valid=0, rf_wren=0 immediately; on release full 128-entry clear repeats.
